// File: rtl/mem_tg_run_sched.sv
// mem_tg_run_sched: run scheduler for the memory traffic-generator array.
// Issues one-cycle start pulses to the masked channels and keeps at most
// MAX_ACTIVE of them in flight. A channel finishes on a rising edge of its
// pass/fail/timeout status or when its watchdog runs out. Aggregate run
// status is reported back to the CSR block.
module mem_tg_run_sched #(
    parameter int NUM_TG     = 4,
    parameter int MAX_ACTIVE = 2,
    parameter int TIMEOUT_W  = 32,
    localparam int CNT_W     = $clog2(NUM_TG + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_start,
    input  logic [NUM_TG-1:0]    run_mask,
    input  logic [TIMEOUT_W-1:0] run_timeout,
    input  logic                 abort,
    input  logic [NUM_TG-1:0]    tg_pass,
    input  logic [NUM_TG-1:0]    tg_fail,
    input  logic [NUM_TG-1:0]    tg_timeout,
    output logic [NUM_TG-1:0]    tg_start,
    output logic                 busy,
    output logic                 done,
    output logic                 run_pass,
    output logic [NUM_TG-1:0]    ch_done,
    output logic [NUM_TG-1:0]    ch_fail,
    output logic [NUM_TG-1:0]    ch_hung,
    output logic                 aborted,
    output logic [CNT_W-1:0]     active_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t               state, state_next;
    logic [NUM_TG-1:0]    mask_r, pending, running;
    logic [TIMEOUT_W-1:0] timeout_r;
    logic [TIMEOUT_W-1:0] watchdog [NUM_TG];
    logic [NUM_TG-1:0]    pass_q, fail_q, tmo_q;

    logic [NUM_TG-1:0]    rise_pass, rise_bad, st_end, wd_end, end_vec;
    logic [NUM_TG-1:0]    run_left, pend_view, issue;
    logic                 load_run, do_abort, enter_finish, may_issue;
    logic [TIMEOUT_W-1:0] issue_timeout;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_TG-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_TG; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    // Status edges are taken against last cycle's sampled levels, so a level
    // already high when a channel starts never counts as a completion.
    assign rise_pass  = tg_pass & ~pass_q;
    assign rise_bad   = (tg_fail & ~fail_q) | (tg_timeout & ~tmo_q);

    assign busy       = (state != IDLE);
    assign done       = (state == FINISH);
    assign active_cnt = popcount(running);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state plus per-cycle control: run acceptance, abort, completion capture.
    always_comb begin
        state_next   = state;
        load_run     = 1'b0;
        do_abort     = 1'b0;
        enter_finish = 1'b0;
        may_issue    = 1'b0;
        st_end       = '0;
        wd_end       = '0;
        case (state)
            IDLE: begin
                if (run_start) begin
                    load_run   = 1'b1;
                    may_issue  = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (pending == '0 && running == '0) begin
                    enter_finish = 1'b1;
                    state_next   = FINISH;
                end else if (abort) begin
                    do_abort = 1'b1;
                end else begin
                    may_issue = 1'b1;
                    st_end    = running & ~tg_start & (rise_pass | rise_bad);
                    for (int i = 0; i < NUM_TG; i++) begin
                        wd_end[i] = (timeout_r != '0) && running[i] &&
                                    (watchdog[i] == TIMEOUT_W'(1)) && !st_end[i];
                    end
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pick the lowest pending channel when a slot is free, counting slots freed this cycle.
    always_comb begin
        end_vec       = st_end | wd_end;
        run_left      = running & ~end_vec;
        pend_view     = load_run ? run_mask : pending;
        issue_timeout = load_run ? run_timeout : timeout_r;
        issue         = '0;
        if (may_issue && (popcount(run_left) < CNT_W'(MAX_ACTIVE))) begin
            for (int i = NUM_TG - 1; i >= 0; i--) begin
                if (pend_view[i]) begin
                    issue    = '0;
                    issue[i] = 1'b1;
                end
            end
        end
    end

    // Run bookkeeping: pending/running sets, channel results, watchdogs, status history.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_q    <= '0;
            fail_q    <= '0;
            tmo_q     <= '0;
            tg_start  <= '0;
            mask_r    <= '0;
            timeout_r <= '0;
            pending   <= '0;
            running   <= '0;
            ch_done   <= '0;
            ch_fail   <= '0;
            ch_hung   <= '0;
            aborted   <= 1'b0;
            run_pass  <= 1'b0;
            for (int i = 0; i < NUM_TG; i++) watchdog[i] <= '0;
        end else begin
            pass_q   <= tg_pass;
            fail_q   <= tg_fail;
            tmo_q    <= tg_timeout;
            tg_start <= issue;
            if (load_run) begin
                mask_r    <= run_mask;
                timeout_r <= run_timeout;
                pending   <= run_mask & ~issue;
                running   <= issue;
                ch_done   <= '0;
                ch_fail   <= '0;
                ch_hung   <= '0;
                aborted   <= 1'b0;
                run_pass  <= 1'b0;
            end else if (do_abort) begin
                pending <= '0;
                running <= '0;
                aborted <= 1'b1;
            end else begin
                pending <= pending & ~issue;
                running <= run_left | issue;
                ch_done <= ch_done | end_vec;
                ch_fail <= ch_fail | (st_end & rise_bad);
                ch_hung <= ch_hung | wd_end;
            end
            if (enter_finish) begin
                run_pass <= (ch_done == mask_r) && (mask_r != '0) &&
                            (ch_fail == '0) && (ch_hung == '0);
            end
            for (int i = 0; i < NUM_TG; i++) begin
                if (issue[i]) begin
                    watchdog[i] <= issue_timeout;
                end else if (running[i] && (timeout_r != '0) && (watchdog[i] != '0)) begin
                    watchdog[i] <= watchdog[i] - TIMEOUT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/mem_tg_run_sched.md
Name: mem_tg_run_sched

Overview:
- Run scheduler for the memory traffic-generator array.
- Takes a channel mask from the TG control CSR logic and issues one-cycle start pulses to the selected TG channels.
- Keeps at most MAX_ACTIVE channels running at once and detects completion on rising edges of the TG pass/fail/timeout status.
- Enforces a per-channel watchdog and reports aggregate run status back to the CSR block.

Parameters:
- NUM_TG, 4: number of traffic-generator channels.
- MAX_ACTIVE, 2: maximum channels running concurrently (1..NUM_TG).
- TIMEOUT_W, 32: width of the watchdog cycle counter.

Ports:
- clk  in  1  Single clock.
- rst  in  1  Synchronous, active-high reset.
- run_start  in  1  Start-run pulse; sampled only in IDLE.
- run_mask  in  NUM_TG  Channels to run; latched on accepted run_start.
- run_timeout  in  TIMEOUT_W  Watchdog limit in cycles per channel; 0 disables it. Latched with run_mask.
- abort  in  1  Abandon the run; level, sampled each cycle.
- tg_pass  in  NUM_TG  TG pass status, level.
- tg_fail  in  NUM_TG  TG fail status, level.
- tg_timeout  in  NUM_TG  TG internal-timeout status, level.
- tg_start  out  NUM_TG  Registered one-cycle start pulse per channel.
- busy  out  1  High from accepted run_start until the done pulse, inclusive.
- done  out  1  One-cycle run-complete pulse.
- run_pass  out  1  All masked channels passed; valid from done until the next accepted run_start.
- ch_done  out  NUM_TG  Channel finished: pass, fail, TG timeout, or watchdog hang.
- ch_fail  out  NUM_TG  Channel ended by tg_fail or tg_timeout.
- ch_hung  out  NUM_TG  Channel ended by the watchdog.
- aborted  out  1  Last run was ended by abort.
- active_cnt  out  clog2(NUM_TG+1)  Channels currently running.

Behaviour:
- Reset: all outputs 0; state IDLE; pending, running and watchdog registers cleared. Reset mid-run drops the run with no done pulse and no further tg_start.
- States: IDLE, RUN, FINISH.
- IDLE:
  - run_start=1 at edge N: latch mask and timeout; pending=run_mask; clear ch_done, ch_fail, ch_hung, aborted and run_pass; busy=1 from N+1; go to RUN.
  - run_start while busy is ignored.
- RUN, issue:
  - Each cycle, if pending≠0 and active_cnt<MAX_ACTIVE, issue the lowest-index pending channel.
  - Issue means: tg_start[i] high for exactly that cycle; clear pending[i]; set running[i]; load watchdog[i]=run_timeout.
  - At most one issue per cycle. The first tg_start is at N+1.
- RUN, edge capture:
  - Status edges are detected against 1-cycle-delayed copies of the status inputs.
  - An edge counts only when running[i]=1 and is not in the issue cycle of channel i, so stale levels from a previous run are masked.
- RUN, completion of channel i (edge seen at edge M):
  - running[i] cleared; ch_done[i]=1 visible at M+1.
  - ch_fail[i]=1 if a fail or timeout edge is present; fail/timeout beats pass when coincident.
  - The freed active slot may be reissued at M+1.
- Watchdog:
  - Applies when run_timeout≠0 and running[i]: decrement watchdog[i] each cycle.
  - Counting 1→0 ends the channel with ch_hung[i]=1 and ch_done[i]=1 and ch_fail[i]=0. It does not wait for the TG.
  - A status edge in the same cycle beats the watchdog.
- RUN exit: when pending=0 and running=0, go to FINISH.
- FINISH:
  - Drive done=1 for one cycle.
  - run_pass = (ch_done==mask) && ch_fail==0 && ch_hung==0.
  - busy drops the cycle after done; return to IDLE.
- Latency: last completion edge at M → done at M+2.
- Abort, when seen in RUN:
  - Clear pending and running; aborted=1; go to FINISH next cycle, so done is at abort+2.
  - ch_* bits for unfinished channels stay 0, so run_pass=0.
  - No tg_start is issued in the abort cycle.
- Empty mask: RUN to FINISH immediately; done at N+2; run_pass=0; no tg_start.
- Mask bits at or above NUM_TG do not exist; active_cnt never exceeds MAX_ACTIVE.
- Status edges on channels that are not running are ignored.

Test Plan:
1. NUM_TG=4, MAX_ACTIVE=2, mask=4'b1111, timeout=0. Pulse tg_pass on each channel 10 cycles after its start.
   - tg_start[0] at N+1 and tg_start[1] at N+2.
   - ch2 starts the cycle after ch0 completes; active_cnt never exceeds 2.
   - done once; run_pass=1; ch_done=4'hF.
2. mask=4'b0101. Hold tg_pass[2]=1 before start, then raise tg_fail[2] 5 cycles after its start; ch0 passes.
   - Stale pass on ch2 is ignored.
   - ch_fail=4'b0100; run_pass=0.
3. mask=4'b0010, timeout=20, no status from ch1.
   - ch_hung[1]=1 exactly 20 cycles after tg_start[1]; done 2 cycles later; run_pass=0.
4. Pass and fail rising in the same cycle on ch0, with a watchdog expiring the same cycle on ch1.
   - ch_fail[0]=1; ch1 marked hung.
5. abort 3 cycles into a mask=4'hF run.
   - No further tg_start; done at abort+2; aborted=1.
   - run_start during busy is ignored.
   - rst mid-run clears all outputs with no done pulse.
6. mask=0.
   - done at N+2; run_pass=0; tg_start stays 0.
